// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider (clk_div_prog).
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int DIV_MIN = 2;

  function automatic int unsigned half_of(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/clk_div_edge_comb.sv
// Dual-edge output stage: negedge resample of clk_p and the final OR that forms clk_out.
// Kept separate so the only falling-edge flop can be constrained on its own.
module clk_div_edge_comb (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clk_p,
  input  logic odd,
  output logic clk_out
);

  logic clk_n_d;
  logic clk_n_q;

  // Masking before the flop keeps clk_out a pure OR of two registers for any divisor.
  always_comb begin
    clk_n_d = clk_p & odd;
  end

  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_n_d;
    end
  end

  assign clk_out = clk_p | clk_n_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with shadowed divisor updates.
// Optional macro CLK_DIV_STROBE_EN adds clk_stb, a clk_in-domain pulse aligned to each clk_out rise.
// rst_n asserts asynchronously and is expected to be released synchronously to clk_in.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             upd_done,
  output logic             div_err,
  output logic             busy
`ifdef CLK_DIV_STROBE_EN
  ,
  output logic             clk_stb
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DIV_FLOOR = CNT_W'(DIV_MIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_p_q, clk_p_d;
  logic             upd_done_q, upd_done_d;
  logic             div_err_q, div_err_d;
  logic             running;
  logic             wrap;
  logic             apply;
  logic             load_low;
  logic [CNT_W-1:0] half_act;

  always_comb begin
    running  = (state_q != IDLE);
    wrap     = running && (cnt_q == div_act_q - CNT_W'(1));
    // A pending divisor only lands on a period boundary, so no period is ever mixed.
    apply    = pend_vld_q && (wrap || (state_q == IDLE));
    load_low = div_load && (div_val < DIV_FLOOR);
    half_act = CNT_W'(half_of(32'(div_act_q)));

    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en) state_d = RUN;
      RUN:      if (!en) state_d = STOPPING;
      STOPPING: begin
        if (en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase

    cnt_d = '0;
    if (running && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // clk_p trails cnt by one cycle, which places the first rise one cycle into RUN.
    clk_p_d = running && (cnt_q < half_act);

    div_act_d  = apply ? pend_q : div_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply) begin
      pend_vld_d = 1'b0;
    end
    if (div_load) begin
      pend_d     = load_low ? DIV_FLOOR : div_val;
      pend_vld_d = 1'b1;
    end

    upd_done_d = apply;
    div_err_d  = load_low;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_act_q  <= DIV_RST;
      pend_q     <= DIV_RST;
      pend_vld_q <= 1'b0;
      clk_p_q    <= 1'b0;
      upd_done_q <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_p_q    <= clk_p_d;
      upd_done_q <= upd_done_d;
      div_err_q  <= div_err_d;
    end
  end

`ifdef CLK_DIV_STROBE_EN
  logic clk_stb_q, clk_stb_d;

  always_comb begin
    clk_stb_d = running && (cnt_q == '0);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_stb_q <= 1'b0;
    end else begin
      clk_stb_q <= clk_stb_d;
    end
  end

  assign clk_stb = clk_stb_q;
`endif

  clk_div_edge_comb u_edge (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .clk_p   (clk_p_q),
    .odd     (div_act_q[0]),
    .clk_out (clk_out)
  );

  assign upd_done = upd_done_q;
  assign div_err  = div_err_q;
  assign busy     = running;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider producing a 50%-duty output for both even and odd divisors.
- Odd divisors use a posedge/negedge half-cycle OR scheme.
- Divisor changes are staged in a shadow register and applied only at a period boundary, so the output never glitches.
- Start/stop is glitch-free.
- Used to generate low-speed peripheral clocks (UART/SPI/LED scan) from the system clock.

Parameters:
- CNT_W, 8, width of divisor and period counter; legal divisors 2..2^CNT_W-1.
- DIV_DEFAULT, 3, divisor loaded at reset; must be in 2..2^CNT_W-1.

Ports:
- clk_in  input  1  source clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request; level-sensitive.
- div_val  input  CNT_W  new divisor N.
- div_load  input  1  one-cycle strobe; captures div_val into the pending register.
- clk_out  output  1  divided clock.
- upd_done  output  1  one-cycle pulse when a pending divisor becomes active.
- div_err  output  1  one-cycle pulse when div_load carried div_val<2.
- busy  output  1  high in RUN or STOPPING.

Behaviour:
- Reset (async assert, sync release on clk_in posedge):
  - cnt=0, div_act=DIV_DEFAULT, pend_vld=0, state=IDLE.
  - clk_p=0, clk_n=0, clk_out=0, upd_done=0, div_err=0, busy=0.
- Period counter cnt (posedge): counts 0..div_act-1 in RUN/STOPPING, wraps to 0; held at 0 in IDLE.
- Output generation:
  - clk_p (posedge reg) = 1 while cnt < floor(div_act/2).
  - clk_n = clk_p resampled on negedge clk_in.
  - Even N: clk_out = clk_p, giving N/2 high and N/2 low.
  - Odd N: clk_out = clk_p | clk_n, giving (N-1)/2+0.5 = N/2 input cycles high.
  - clk_out must come from registers through at most one OR gate. No other logic.
- First rising edge of clk_out: one clk_in cycle after entering RUN.
- FSM:
  - IDLE --en=1--> RUN; cnt starts at 0 on the next posedge.
  - RUN --en=0--> STOPPING; the current period completes.
  - STOPPING --wrap & en=0--> IDLE, with clk_out low.
  - STOPPING --en=1--> RUN with no break in the output.
- Divisor update:
  - div_load=1: pend <= max(div_val,2), pend_vld <= 1.
  - If div_val<2, div_err pulses on the next cycle.
  - A later div_load before application overwrites pend (last one wins).
  - Application happens at cnt wrap (cnt==div_act-1) in RUN/STOPPING, or on the next posedge in IDLE: div_act <= pend, pend_vld <= 0, upd_done pulses the same cycle.
  - div_load coincident with the application cycle: the old pend is applied; the new value stays pending for the next wrap.
- No output period ever has a mixed length. Every period is entirely old N or entirely new N.
- Reset mid-period: clk_out drops immediately (async). div_act returns to DIV_DEFAULT and any pending value is discarded.

Optional Feature:
- Macro: CLK_DIV_STROBE_EN.
- Defined: adds output clk_stb (1 bit), a one-cycle clk_in pulse on the posedge where cnt==0 in RUN/STOPPING. It is aligned with each clk_out rising edge and intended as a clock-enable for logic kept in the clk_in domain. Reset value 0.
- Undefined: the port is absent and the logic is not built. All other behaviour is identical.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum {IDLE, RUN, STOPPING};
  - constant DIV_MIN=2;
  - a function half_of(N) returning floor(N/2).
- One sub-module, clk_div_edge_comb, holds the negedge resample and the even/odd output OR. This isolates the only dual-edge logic for timing constraints.
- The counter, FSM and shadow register stay in the top module.

Test Plan:
- Reset with DIV_DEFAULT=3, en=1 → clk_out period 3 clk_in cycles, high 1.5 cycles (measured on both edges), busy=1 from cycle 1.
- div_load with 4 while running N=3 → the current 3-cycle period completes, upd_done pulses at wrap, then the output is 2 high / 2 low; no runt pulse.
- div_load with 7, then with 5 two cycles later, before the wrap → only 5 is applied (high 2.5, low 2.5); one upd_done.
- div_load with 0 → div_err pulses; divisor 2 is applied (1 high / 1 low).
- Drop en mid-period at N=6, cnt=2 → the output finishes the period, then stays low with busy=0. Re-raising en during STOPPING continues without a gap.
- Assert rst_n=0 at cnt=1 of N=5 → clk_out=0 immediately. After release with en=1, N=3 resumes with the first rising edge one cycle later.
